// File: rtl/stream_dmux_if.sv
// Stream interface bundle for stream_dmux: one input port and OUTPUTS output ports.
// STREAM_DMUX_BCAST_EN adds the in_bcast sideband.
interface stream_dmux_if #(
    parameter int WIDTH   = 32,
    parameter int OUTPUTS = 4,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = $clog2(OUTPUTS);

    logic [WIDTH-1:0]   in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
`ifdef STREAM_DMUX_BCAST_EN
    logic               in_bcast;
`endif
    logic [WIDTH-1:0]   out_data [OUTPUTS];
    logic [OUTPUTS-1:0] out_valid;
    logic [OUTPUTS-1:0] out_ready;
    logic               oob_pulse;
    logic [CNT_W-1:0]   oob_count;

    // Producer and consumers together form the master side.
    modport master (
`ifdef STREAM_DMUX_BCAST_EN
        output in_bcast,
`endif
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, oob_pulse, oob_count
    );

    modport slave (
`ifdef STREAM_DMUX_BCAST_EN
        input  in_bcast,
`endif
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, oob_pulse, oob_count
    );
endinterface

// File: rtl/stream_dmux.sv
// Registered 1-to-OUTPUTS stream demultiplexer with a one-deep holding register per output.
// Define STREAM_DMUX_BCAST_EN to add in_bcast (load every output from one beat).
module stream_dmux #(
    parameter int WIDTH   = 32,
    parameter int OUTPUTS = 4,
    parameter int CNT_W   = 16
) (
    input logic          clk,
    input logic          rst_n,
    stream_dmux_if.slave bus
);
    localparam int SEL_W = $clog2(OUTPUTS);
    localparam int SEL_N = 1 << SEL_W;

    logic [WIDTH-1:0]   r_data [OUTPUTS];
    logic [OUTPUTS-1:0] r_valid;
    logic               r_oob_pulse;
    logic [CNT_W-1:0]   r_oob_count;

    logic [OUTPUTS-1:0] w_slot_free;
    logic [OUTPUTS-1:0] w_load;
    logic [SEL_N-1:0]   w_free_by_sel;
    logic               w_bcast;
    logic               w_in_range;
    logic               w_ready;
    logic               w_fire;
    logic               w_oob;

`ifdef STREAM_DMUX_BCAST_EN
    assign w_bcast = bus.in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // A slot can take a new beat if empty or being drained this same cycle.
    assign w_slot_free = ~r_valid | bus.out_ready;

    generate
        if (SEL_N == OUTPUTS) begin : g_pow2
            assign w_in_range = 1'b1;
        end else begin : g_npow2
            assign w_in_range = (bus.in_sel < SEL_W'(OUTPUTS));
        end
    endgenerate

    // Unused select codes read as always-free so out-of-range beats are sunk.
    always_comb begin
        // NOTE: every always_comb output gets a full default first so no latch is inferred.
        w_free_by_sel                = '1;
        w_free_by_sel[OUTPUTS-1:0]   = w_slot_free;
    end

    assign w_ready = w_bcast ? (&w_slot_free) : w_free_by_sel[bus.in_sel];
    assign w_fire  = bus.in_valid && w_ready;
    assign w_oob   = w_fire && !w_bcast && !w_in_range;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < OUTPUTS; i++) begin
            w_load[i] = w_fire && (w_bcast || (bus.in_sel == SEL_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            // NOTE: the data registers are reset too, since out_data must read 0 during reset.
            for (int i = 0; i < OUTPUTS; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            for (int i = 0; i < OUTPUTS; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= bus.in_data;
                end else if (bus.out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oob_pulse <= 1'b0;
            r_oob_count <= '0;
        end else begin
            r_oob_pulse <= w_oob;
            if (w_oob && (r_oob_count != '1)) begin
                r_oob_count <= r_oob_count + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
    assign bus.oob_pulse = r_oob_pulse;
    assign bus.oob_count = r_oob_count;

    generate
        for (genvar g = 0; g < OUTPUTS; g++) begin : g_out
            assign bus.out_data[g] = r_data[g];
        end
    endgenerate
endmodule
